// File: rtl/maze_pkg.sv
// Shared types and constants for the maze game countdown timer.
package maze_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSE   = 2'd2,
    EXPIRED = 2'd3
  } timer_state_t;

  typedef logic [3:0] bcd_nibble_t;

  localparam logic [7:0] BCD_ZERO = 8'h00;

  function automatic logic is_bcd(input logic [7:0] value);
    return (value[7:4] <= 4'd9) && (value[3:0] <= 4'd9);
  endfunction

endpackage

// File: rtl/maze_bcd_dec2.sv
// Combinational two-digit BCD decrement; also flags the 01 -> 00 step.
module maze_bcd_dec2
  import maze_pkg::*;
(
  input  logic [7:0] value,
  output logic [7:0] dec,
  output logic       is_one
);

  bcd_nibble_t ones;
  bcd_nibble_t tens;

  always_comb begin
    ones = value[3:0];
    tens = value[7:4];
    if (ones != 4'd0) begin
      dec = {tens, ones - 4'd1};
    end else begin
      dec = {tens - 4'd1, 4'd9};
    end
  end

  assign is_one = (value == 8'h01);

endmodule

// File: rtl/maze_game_timer.sv
// Countdown timer for the maze game: BCD seconds, freeze on request,
// timeout level once the count reaches zero.
module maze_game_timer
  import maze_pkg::*;
#(
  parameter int         TICKS     = 50000000,
  parameter int         PRE_W     = 26,
  parameter logic [7:0] START_BCD = 8'h60
) (
  input  logic       clk,
  input  logic       nst,
  input  logic       start,
  input  logic       timecheckstop,
  output logic       timeout,
  output logic [7:0] number,
  output logic       running,
  output logic       sec_tick
);

  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICKS - 1);
  localparam bit PARAMS_OK = (TICKS >= 2) && is_bcd(START_BCD) &&
                             ((PRE_W >= 32) || ((64'd1 << PRE_W) >= 64'(TICKS)));

  always_comb begin : param_check
    assert (PARAMS_OK) else $error("maze_game_timer: illegal TICKS/PRE_W/START_BCD");
  end

  timer_state_t     state_reg, state_next;
  logic [PRE_W-1:0] pre_reg, pre_next;
  logic [7:0]       number_reg, number_next;
  logic             timeout_reg, timeout_next;
  logic             tick_reg, tick_next;
  logic             running_reg, running_next;

  logic [7:0] number_dec;
  logic       number_is_one;
  logic       tick_due;

  maze_bcd_dec2 u_dec (
    .value  (number_reg),
    .dec    (number_dec),
    .is_one (number_is_one)
  );

  assign tick_due = (pre_reg == PRE_MAX);

  always_ff @(posedge clk) begin
    if (!nst) begin
      state_reg   <= IDLE;
      pre_reg     <= '0;
      number_reg  <= START_BCD;
      timeout_reg <= 1'b0;
      tick_reg    <= 1'b0;
      running_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      pre_reg     <= pre_next;
      number_reg  <= number_next;
      timeout_reg <= timeout_next;
      tick_reg    <= tick_next;
      running_reg <= running_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (start) begin
      state_next = (START_BCD == BCD_ZERO) ? EXPIRED : RUN;
    end else begin
      case (state_reg)
        RUN: begin
          if (timecheckstop) begin
            state_next = PAUSE;
          end else if (tick_due && (number_is_one || number_reg == BCD_ZERO)) begin
            state_next = EXPIRED;
          end
        end
        PAUSE: begin
          if (!timecheckstop) begin
            state_next = RUN;
          end
        end
        default: state_next = state_reg;
      endcase
    end
  end

  // Freeze wins over a due tick, so the prescaler simply holds while paused.
  always_comb begin
    pre_next     = pre_reg;
    number_next  = number_reg;
    timeout_next = timeout_reg;
    tick_next    = 1'b0;
    running_next = (state_next == RUN);
    if (start) begin
      pre_next     = '0;
      number_next  = START_BCD;
      timeout_next = (START_BCD == BCD_ZERO);
    end else if (state_reg == RUN && !timecheckstop) begin
      if (tick_due) begin
        pre_next = '0;
        if (number_reg != BCD_ZERO) begin
          number_next = number_dec;
          tick_next   = 1'b1;
          if (number_is_one) begin
            timeout_next = 1'b1;
          end
        end
      end else begin
        pre_next = pre_reg + 1'b1;
      end
    end
  end

  assign timeout  = timeout_reg;
  assign number   = number_reg;
  assign running  = running_reg;
  assign sec_tick = tick_reg;

endmodule

// File: tb/tb_maze_game_timer.sv
// Directed bench for maze_game_timer with TICKS=4 (plus START_BCD 10 and 00 instances).
module tb_maze_game_timer;

  logic clk = 1'b0;
  logic nst;
  logic start_a, tcs_a, start_b, tcs_b, start_c, tcs_c;
  logic       timeout_a, running_a, tick_a;
  logic [7:0] number_a;
  logic       timeout_b, running_b, tick_b;
  logic [7:0] number_b;
  logic       timeout_c, running_c, tick_c;
  logic [7:0] number_c;

  int checks   = 0;
  int failures = 0;
  int tick_cnt = 0;

  typedef struct {
    logic       start;
    logic       tcs;
    logic [7:0] num;
    logic       timeout;
    logic       running;
    logic       tick;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  maze_game_timer #(.TICKS(4), .PRE_W(3), .START_BCD(8'h12)) dut_a (
    .clk(clk), .nst(nst), .start(start_a), .timecheckstop(tcs_a),
    .timeout(timeout_a), .number(number_a), .running(running_a), .sec_tick(tick_a));

  maze_game_timer #(.TICKS(4), .PRE_W(3), .START_BCD(8'h10)) dut_b (
    .clk(clk), .nst(nst), .start(start_b), .timecheckstop(tcs_b),
    .timeout(timeout_b), .number(number_b), .running(running_b), .sec_tick(tick_b));

  maze_game_timer #(.TICKS(4), .PRE_W(3), .START_BCD(8'h00)) dut_c (
    .clk(clk), .nst(nst), .start(start_c), .timecheckstop(tcs_c),
    .timeout(timeout_c), .number(number_c), .running(running_c), .sec_tick(tick_c));

  // Counted on the rising edge so the bench can clear/read it safely at the falling edge.
  always @(posedge clk) begin
    if (tick_a) tick_cnt++;
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_a(input string tag, input logic [7:0] num, input logic to,
                         input logic run, input logic tk);
    check({tag, ".number"},   number_a,  num);
    check({tag, ".timeout"},  {7'd0, timeout_a}, {7'd0, to});
    check({tag, ".running"},  {7'd0, running_a}, {7'd0, run});
    check({tag, ".sec_tick"}, {7'd0, tick_a},    {7'd0, tk});
  endtask

  function automatic logic [7:0] to_bcd(input int s);
    logic [3:0] t, o;
    t = 4'(s / 10);
    o = 4'(s % 10);
    return {t, o};
  endfunction

  function automatic void add(input logic s, input logic t, input logic [7:0] n,
                              input logic to, input logic r, input logic tk);
    vec_t v;
    v.start = s; v.tcs = t; v.num = n; v.timeout = to; v.running = r; v.tick = tk;
    vecs.push_back(v);
  endfunction

  initial begin
    int sec;
    vec_t v;

    // Start, first decrement, freeze with prescaler at 2, release, next decrement.
    add(1, 0, 8'h12, 0, 1, 0);
    for (int i = 0; i < 3; i++) add(0, 0, 8'h12, 0, 1, 0);
    add(0, 0, 8'h11, 0, 1, 1);
    add(0, 0, 8'h11, 0, 1, 0);
    add(0, 0, 8'h11, 0, 1, 0);
    for (int i = 0; i < 20; i++) add(0, 1, 8'h11, 0, 0, 0);
    add(0, 0, 8'h11, 0, 1, 0);
    add(0, 0, 8'h11, 0, 1, 0);
    add(0, 0, 8'h10, 0, 1, 1);

    nst = 1'b0;
    start_a = 0; tcs_a = 0; start_b = 0; tcs_b = 0; start_c = 0; tcs_c = 0;
    repeat (2) @(negedge clk);
    check_a("reset", 8'h12, 0, 0, 0);
    nst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_a("idle", 8'h12, 0, 0, 0);
    end

    // Tens borrow on the 10 instance, zero-start on the 00 instance.
    start_b = 1; start_c = 1;
    @(negedge clk);
    start_b = 0; start_c = 0;
    check("b_start.number", number_b, 8'h10);
    check("b_start.running", {7'd0, running_b}, 8'd1);
    check("c_start.timeout", {7'd0, timeout_c}, 8'd1);
    check("c_start.number", number_c, 8'h00);
    check("c_start.running", {7'd0, running_c}, 8'd0);
    for (int j = 1; j <= 4; j++) begin
      @(negedge clk);
      check("b_borrow.number", number_b, (j == 4) ? 8'h09 : 8'h10);
      check("b_borrow.nibbles", {7'd0, (number_b[7:4] <= 4'd9) && (number_b[3:0] <= 4'd9)}, 8'd1);
      check("c_hold.sec_tick", {7'd0, tick_c}, 8'd0);
    end

    tick_cnt = 0;
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      start_a = v.start;
      tcs_a   = v.tcs;
      @(negedge clk);
      check_a($sformatf("vec%0d", i), v.num, v.timeout, v.running, v.tick);
    end
    start_a = 0; tcs_a = 0;

    for (int j = 1; j <= 40; j++) begin
      @(negedge clk);
      sec = 10 - j / 4;
      check_a($sformatf("cont%0d", j), to_bcd(sec), sec == 0, sec != 0, (j % 4) == 0);
    end
    for (int j = 0; j < 20; j++) begin
      tcs_a = (j >= 10);
      @(negedge clk);
      check_a("expired_hold", 8'h00, 1, 0, 0);
    end
    tcs_a = 0;
    check("tick_count_freeze_run", 8'(tick_cnt), 8'd12);

    // start beats timecheckstop in EXPIRED, then the freeze takes effect.
    start_a = 1; tcs_a = 1;
    @(negedge clk);
    start_a = 0;
    check_a("restart_prio", 8'h12, 0, 1, 0);
    @(negedge clk);
    check_a("restart_pause", 8'h12, 0, 0, 0);

    // Clean countdown from start at edge k.
    tcs_a = 0; start_a = 1;
    @(negedge clk);
    start_a = 0;
    tick_cnt = 0;
    check_a("clean_k", 8'h12, 0, 1, 0);
    for (int j = 1; j <= 48; j++) begin
      @(negedge clk);
      sec = 12 - j / 4;
      check_a($sformatf("clean%0d", j), to_bcd(sec), sec == 0, sec != 0, (j % 4) == 0);
    end
    repeat (2) @(negedge clk);
    check("tick_count_clean", 8'(tick_cnt), 8'd12);
    check_a("clean_after", 8'h00, 1, 0, 0);

    // Mid-count reset at 07.
    start_a = 1;
    @(negedge clk);
    start_a = 0;
    repeat (20) @(negedge clk);
    check("mid.number_before", number_a, 8'h07);
    nst = 0;
    @(negedge clk);
    nst = 1;
    check_a("mid_reset", 8'h12, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_a("post_reset_idle", 8'h12, 0, 0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/maze_game_timer.md
Name: maze_game_timer

Overview:
- Countdown timer for the maze game. It sits directly upstream of the command/controller stage.
- Produces the `timeout` level that the controller consumes. Obeys the controller's `timecheckstop` freeze request.
- Exports the remaining seconds as the 8-bit BCD `number` bus used by the display path.
- Started and restarted by a one-cycle `start` pulse from the controller.

Parameters:
- TICKS, 50000000, clk cycles per game second; legal range ≥ 2.
- PRE_W, 26, prescaler width; requires 2^PRE_W ≥ TICKS.
- START_BCD, 8'h60, initial remaining time in BCD; each nibble must be 0-9.

Ports:
- clk, input, 1, system clock; all state changes on the rising edge.
- nst, input, 1, reset; synchronous, active-low. One clock; nst is sampled only on the rising edge of clk.
- start, input, 1, one-cycle pulse; loads START_BCD and begins counting.
- timecheckstop, input, 1, level; while high, countdown is frozen (maze solved / paused).
- timeout, output, 1, high from the moment number reaches 00 until the next start or reset.
- number, output, 8, remaining seconds in BCD; [7:4] = tens, [3:0] = ones.
- running, output, 1, high in RUN state only.
- sec_tick, output, 1, one-cycle pulse coincident with each number decrement.

Behaviour:
- Reset (nst=0 at an edge):
  - state = IDLE, number = START_BCD, timeout = 0, running = 0, sec_tick = 0, prescaler = 0.
  - Reset overrides all other inputs, including mid-count.
- States: IDLE, RUN, PAUSE, EXPIRED. All outputs are registered.
- start priority: start = 1 in any state (outside reset) at an edge does all of the following:
  - number <= START_BCD, prescaler <= 0, timeout <= 0.
  - Next state is RUN. If START_BCD == 8'h00, next state is EXPIRED and timeout <= 1 instead.
  - start has priority over timecheckstop and over a coincident tick.
- IDLE: holds until start.
- RUN:
  - If timecheckstop = 1: next state PAUSE, prescaler holds, no decrement. This applies even if the prescaler is at TICKS-1.
  - Otherwise, if prescaler == TICKS-1: prescaler <= 0, sec_tick <= 1, number <= number BCD-minus-1.
  - Otherwise: prescaler <= prescaler + 1, sec_tick <= 0.
- BCD decrement:
  - ones != 0: ones - 1.
  - ones == 0: ones = 9, tens - 1.
  - The decrement is never applied at 00.
- Expiry: on the decrement that produces 8'h00, the same edge sets timeout <= 1 and state <= EXPIRED.
- PAUSE:
  - number, prescaler and timeout are held; running = 0.
  - timecheckstop = 0: return to RUN. The prescaler resumes from its held value, so no partial second is lost or restarted.
- EXPIRED:
  - number = 00, timeout = 1, running = 0.
  - timecheckstop is ignored; only start or reset leaves this state.
- Latency:
  - start sampled at edge k: reload is visible after edge k.
  - First decrement is visible after edge k+TICKS, provided there is no freeze.
  - A full countdown from N seconds takes N·TICKS cycles.
- sec_tick: exactly one cycle wide. It is never asserted in IDLE, PAUSE or EXPIRED, except on the final expiring decrement.
- Illegal parameters (non-BCD START_BCD, TICKS < 2): simulation assertion at elaboration/time 0; behaviour otherwise undefined.

Decomposition:
- Shared package maze_pkg:
  - timer state enum (IDLE/RUN/PAUSE/EXPIRED).
  - BCD_ZERO constant.
  - BCD nibble type.
- One sub-module is natural: maze_bcd_dec2, a combinational 2-digit BCD decrementer.
  - Inputs: 8-bit value. Outputs: decremented value and is_one flag (input == 8'h01).
  - The timer uses is_one to raise timeout on the same edge as the final decrement.

Test Plan (TICKS=4, START_BCD=8'h12 unless noted):
- Reset and idle: hold nst=0 for 2 cycles, then idle for 10 cycles -> number = 8'h12, timeout = 0, running = 0, sec_tick never high.
- Full countdown:
  - Pulse start at edge k -> running = 1 after k.
  - number = 8'h11 and sec_tick = 1 after edge k+4.
  - number = 8'h00 and timeout = 1 after edge k+48.
  - Exactly 12 sec_tick pulses; number stays 00 for the following 20 cycles.
- Tens borrow: START_BCD = 8'h10, pulse start -> after 4 cycles number = 8'h09; never an illegal nibble (A-F) on number.
- Freeze:
  - Assert timecheckstop 2 cycles after a decrement, hold 20 cycles -> number unchanged, running = 0, no sec_tick.
  - Release -> next decrement exactly 2 cycles after release.
- Restart and priority:
  - In EXPIRED, pulse start together with timecheckstop = 1 -> after that edge timeout = 0 and number = 8'h12. State goes to RUN, then PAUSE next edge.
  - START_BCD = 8'h00 with start -> timeout = 1 after one edge.
- Mid-count reset: drive nst = 0 for 1 cycle at number = 8'h07 -> after that edge number = 8'h12, state IDLE, timeout = 0, running = 0; no counting until the next start.
